// File: rtl/axis_pkg.sv
// axis_pkg
//   Shared types and helpers for the AXI-Stream width downsizer.
//   - FSM_STATE   : IDLE (hold register empty) / EMIT (serialising a beat)
//   - popcount    : number of set bits in a byte-qualifier vector
//   - lanes_valid : one bit per narrow lane, set when the lane carries any byte
//   Helpers are written against fixed maximum widths so one package serves
//   every parameterisation of the downsizer; callers zero-extend their keep
//   vectors and pass the lane geometry as constant arguments.
package axis_pkg;

    // Default geometry of the bridge front end.
    localparam int DEF_S_DATA_WIDTH = 64;
    localparam int DEF_M_DATA_WIDTH = 32;
    localparam int DEF_RATIO        = DEF_S_DATA_WIDTH / DEF_M_DATA_WIDTH;
    localparam int DEF_LANE_BYTES   = DEF_M_DATA_WIDTH / 8;

    // Widest supported keep vector (512-bit input) and lane count.
    localparam int KEEP_MAX  = 64;
    localparam int RATIO_MAX = 16;
    localparam int POP_W     = $clog2(KEEP_MAX + 1);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } FSM_STATE;

    function automatic logic [POP_W-1:0] popcount(input logic [KEEP_MAX-1:0] keep);
        logic [POP_W-1:0] cnt;
        cnt = '0;
        for (int b = 0; b < KEEP_MAX; b++) begin
            cnt = cnt + POP_W'(keep[b]);
        end
        return cnt;
    endfunction

    // Lanes beyond 'ratio' always read as empty.
    function automatic logic [RATIO_MAX-1:0] lanes_valid(input logic [KEEP_MAX-1:0] keep,
                                                         input int laneBytes,
                                                         input int ratio);
        logic [RATIO_MAX-1:0] mask;
        mask = '0;
        for (int k = 0; k < RATIO_MAX; k++) begin
            for (int b = 0; b < KEEP_MAX; b++) begin
                if (k < ratio && b >= k * laneBytes && b < (k + 1) * laneBytes && keep[b]) begin
                    mask[k] = 1'b1;
                end
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/axis_lane_select.sv
// axis_lane_select
//   Combinational priority finder over a lane-valid mask.
//   Ports:
//     mask_i    : one bit per lane, set when the lane holds data
//     idx_i     : reference lane index
//     incl_i    : 1 = search from idx_i inclusive, 0 = strictly above idx_i
//     next_o    : lowest valid lane satisfying the search (0 when none)
//     final_o   : no valid lane satisfies the search
//   Used once with incl_i=1/idx_i=0 to find the first lane of a fresh beat,
//   and once with incl_i=0 on the current lane to find the next one.
module axis_lane_select #(
    parameter int RATIO = 2,
    parameter int IDX_W = 1
) (
    input  logic [RATIO-1:0] mask_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic             incl_i,
    output logic [IDX_W-1:0] next_o,
    output logic             final_o
);

    // Scan from the top down so the last hit is the lowest qualifying lane.
    always_comb begin
        next_o  = '0;
        final_o = 1'b1;
        for (int k = RATIO - 1; k >= 0; k--) begin
            if (mask_i[k] && ((k > int'(idx_i)) || (incl_i && (k == int'(idx_i))))) begin
                next_o  = IDX_W'(k);
                final_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/axis_width_downsizer.sv
// axis_width_downsizer
//   Serialises wide AXI-Stream beats into narrow lanes (lane 0 first), drops
//   lanes with an all-zero tkeep slice, and reports the byte length of every
//   completed frame.
//   Ports:
//     axi_aclk / axi_aresetn        : clock, asynchronous active-low reset
//     s_axis_*                      : wide input stream (S_DATA_WIDTH)
//     m_axis_*                      : narrow output stream (M_DATA_WIDTH)
//     frame_len / frame_len_valid   : byte count of the frame just closed,
//                                     qualified by a one-cycle pulse
module axis_width_downsizer
    import axis_pkg::*;
#(
    parameter int S_DATA_WIDTH    = 64,
    parameter int M_DATA_WIDTH    = 32,
    parameter int USER_WIDTH      = 1,
    parameter int FRAME_LEN_WIDTH = 16
) (
    input  logic                       axi_aclk,
    input  logic                       axi_aresetn,
    input  logic [S_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [S_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic                       s_axis_tlast,
    input  logic [USER_WIDTH-1:0]      s_axis_tuser,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic [M_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [M_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic                       m_axis_tlast,
    output logic [USER_WIDTH-1:0]      m_axis_tuser,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [FRAME_LEN_WIDTH-1:0] frame_len,
    output logic                       frame_len_valid
);

    localparam int RATIO      = S_DATA_WIDTH / M_DATA_WIDTH;
    localparam int LANE_BYTES = M_DATA_WIDTH / 8;
    localparam int KEEP_W     = S_DATA_WIDTH / 8;
    localparam int IDX_W      = (RATIO > 1) ? $clog2(RATIO) : 1;

    FSM_STATE                   state_q;
    logic [S_DATA_WIDTH-1:0]    data_q;
    logic [KEEP_W-1:0]          keep_q;
    logic                       last_q;
    logic [USER_WIDTH-1:0]      user_q;
    logic [RATIO-1:0]           mask_q;
    logic [IDX_W-1:0]           lane_q;
    logic [FRAME_LEN_WIDTH-1:0] byteCnt_q;
    logic [FRAME_LEN_WIDTH-1:0] byteCnt_d;
    logic [FRAME_LEN_WIDTH-1:0] frameLen_q;
    logic                       frameLenValid_q;

    logic [RATIO_MAX-1:0]       inMaskAll;
    logic [RATIO-1:0]           inMask;
    logic [IDX_W-1:0]           firstLane;
    logic                       noInLanes;
    logic [IDX_W-1:0]           nextLane;
    logic                       finalLane;
    logic                       inHs;
    logic                       outHs;
    logic [M_DATA_WIDTH-1:0]    dataLanes [RATIO];
    logic [LANE_BYTES-1:0]      keepLanes [RATIO];
    logic [POP_W-1:0]           laneBytes;
    logic [FRAME_LEN_WIDTH:0]   sumWide;

    assign inMaskAll = lanes_valid(KEEP_MAX'(s_axis_tkeep), LANE_BYTES, RATIO);
    assign inMask    = inMaskAll[RATIO-1:0];

    axis_lane_select #(.RATIO(RATIO), .IDX_W(IDX_W)) u_firstLane (
        .mask_i  (inMask),
        .idx_i   ('0),
        .incl_i  (1'b1),
        .next_o  (firstLane),
        .final_o (noInLanes)
    );

    axis_lane_select #(.RATIO(RATIO), .IDX_W(IDX_W)) u_nextLane (
        .mask_i  (mask_q),
        .idx_i   (lane_q),
        .incl_i  (1'b0),
        .next_o  (nextLane),
        .final_o (finalLane)
    );

    always_comb begin
        for (int k = 0; k < RATIO; k++) begin
            dataLanes[k] = data_q[k*M_DATA_WIDTH +: M_DATA_WIDTH];
            keepLanes[k] = keep_q[k*LANE_BYTES +: LANE_BYTES];
        end
    end

    // Every output is taken from the hold register, so it cannot move while
    // the sink stalls.
    assign m_axis_tvalid   = (state_q == EMIT);
    assign m_axis_tdata    = dataLanes[lane_q];
    assign m_axis_tkeep    = keepLanes[lane_q];
    assign m_axis_tuser    = user_q;
    assign m_axis_tlast    = last_q & finalLane;
    assign frame_len       = frameLen_q;
    assign frame_len_valid = frameLenValid_q;

    // Refill in the same cycle the final lane leaves, so full beats stream
    // without bubbles.
    assign s_axis_tready = axi_aresetn &
                           ((state_q == IDLE) | (finalLane & m_axis_tready));
    assign inHs  = s_axis_tvalid & s_axis_tready;
    assign outHs = m_axis_tvalid & m_axis_tready;

    // Saturating frame byte accumulator; the extra top bit flags overflow.
    assign laneBytes = popcount(KEEP_MAX'(m_axis_tkeep));
    assign sumWide   = {1'b0, byteCnt_q} + (FRAME_LEN_WIDTH + 1)'(laneBytes);
    assign byteCnt_d = sumWide[FRAME_LEN_WIDTH] ? '1 : sumWide[FRAME_LEN_WIDTH-1:0];

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q         <= IDLE;
            data_q          <= '0;
            keep_q          <= '0;
            last_q          <= 1'b0;
            user_q          <= '0;
            mask_q          <= '0;
            lane_q          <= '0;
            byteCnt_q       <= '0;
            frameLen_q      <= '0;
            frameLenValid_q <= 1'b0;
        end else begin
            frameLenValid_q <= 1'b0;

            if (outHs) begin
                if (m_axis_tlast) begin
                    frameLen_q      <= byteCnt_d;
                    frameLenValid_q <= 1'b1;
                    byteCnt_q       <= '0;
                end else begin
                    byteCnt_q <= byteCnt_d;
                end
            end

            if (inHs) begin
                data_q <= s_axis_tdata;
                keep_q <= s_axis_tkeep;
                last_q <= s_axis_tlast;
                user_q <= s_axis_tuser;
                mask_q <= inMask;
                lane_q <= firstLane;
                // An empty beat still closes its frame with a keep-0 lane 0;
                // an empty non-final beat is simply swallowed.
                state_q <= (noInLanes && !s_axis_tlast) ? IDLE : EMIT;
            end else if (outHs) begin
                if (finalLane) begin
                    state_q <= IDLE;
                end else begin
                    lane_q <= nextLane;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_width_downsizer.sv
// tb_axis_width_downsizer
//   Drives directed and random beats into the downsizer, predicts the narrow
//   lane sequence and frame lengths from the lane rules, and compares every
//   output handshake and frame_len pulse against those predictions.
module tb_axis_width_downsizer;

    localparam int S_W   = 64;
    localparam int M_W   = 32;
    localparam int U_W   = 1;
    localparam int FL_W  = 16;
    localparam int RATIO = S_W / M_W;
    localparam int LB    = M_W / 8;

    logic            axi_aclk;
    logic            axi_aresetn;
    logic [S_W-1:0]  s_axis_tdata;
    logic [S_W/8-1:0] s_axis_tkeep;
    logic            s_axis_tlast;
    logic [U_W-1:0]  s_axis_tuser;
    logic            s_axis_tvalid;
    logic            s_axis_tready;
    logic [M_W-1:0]  m_axis_tdata;
    logic [M_W/8-1:0] m_axis_tkeep;
    logic            m_axis_tlast;
    logic [U_W-1:0]  m_axis_tuser;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic [FL_W-1:0] frame_len;
    logic            frame_len_valid;

    axis_width_downsizer #(
        .S_DATA_WIDTH(S_W), .M_DATA_WIDTH(M_W), .USER_WIDTH(U_W), .FRAME_LEN_WIDTH(FL_W)
    ) dut (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
        .s_axis_tuser(s_axis_tuser), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .frame_len(frame_len), .frame_len_valid(frame_len_valid)
    );

    initial axi_aclk = 1'b0;
    always #5 axi_aclk = ~axi_aclk;

    int cycleCount = 0;
    always @(posedge axi_aclk) cycleCount++;

    int compareCount = 0;
    int failCount    = 0;

    // Expected lanes packed as {user, last, keep, data}.
    logic [37:0] expQ [$];
    int          lenQ [$];
    int          frameSum = 0;

    int readyMode = 0;
    always @(posedge axi_aclk) begin
        #1;
        m_axis_tready = (readyMode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference model: split the accepted beat into lanes from the keep rules.
    task automatic modelBeat(input logic [S_W-1:0] data, input logic [S_W/8-1:0] keep,
                             input logic last, input logic [U_W-1:0] user);
        int highest;
        logic [LB-1:0] slice;
        highest = -1;
        for (int k = 0; k < RATIO; k++) begin
            slice = keep[k*LB +: LB];
            if (slice != 0) highest = k;
        end
        for (int k = 0; k < RATIO; k++) begin
            slice = keep[k*LB +: LB];
            if (slice != 0)
                expQ.push_back({user, last && (k == highest), slice, data[k*M_W +: M_W]});
        end
        if (highest < 0 && last)
            expQ.push_back({user, 1'b1, {LB{1'b0}}, data[M_W-1:0]});
        frameSum += $countones(keep);
        if (last) begin
            lenQ.push_back((frameSum > 65535) ? 65535 : frameSum);
            frameSum = 0;
        end
    endtask

    task automatic applyStimulus(input logic [S_W-1:0] data, input logic [S_W/8-1:0] keep,
                                 input logic last, input logic [U_W-1:0] user,
                                 output int waits);
        bit done;
        s_axis_tdata  = data;
        s_axis_tkeep  = keep;
        s_axis_tlast  = last;
        s_axis_tuser  = user;
        s_axis_tvalid = 1'b1;
        waits = 0;
        done  = 0;
        while (!done) begin
            @(negedge axi_aclk);
            if (s_axis_tready) begin
                done = 1;
                modelBeat(data, keep, last, user);
            end else begin
                waits++;
                if (waits > 300) begin
                    checkOutput("in_timeout", 64'(waits), 64'(0));
                    done = 1;
                end
            end
        end
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((expQ.size() != 0 || lenQ.size() != 0) && n < 3000) begin
            @(posedge axi_aclk);
            n++;
        end
        if (n >= 3000) checkOutput("drain_timeout", 64'(expQ.size() + lenQ.size()), 64'(0));
        repeat (2) @(posedge axi_aclk);
        #1;
    endtask

    // Output monitor: lane order, stall stability and frame length pulses.
    bit          stallValid = 0;
    logic [37:0] stallSnap;
    logic [37:0] curr;
    logic [37:0] expBeat;
    int          outHsCount = 0;
    int          burstFirst = -1;
    int          lastOutCycle = 0;
    int          expLen;

    always @(negedge axi_aclk) begin
        if (!axi_aresetn) begin
            stallValid = 0;
        end else begin
            curr = {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
            if (stallValid)
                checkOutput("stall_hold", 64'({m_axis_tvalid, curr}), 64'({1'b1, stallSnap}));
            if (m_axis_tvalid && m_axis_tready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_beat", 64'(curr), 64'(0));
                end else begin
                    expBeat = expQ.pop_front();
                    checkOutput("out_beat", 64'(curr), 64'(expBeat));
                end
                outHsCount++;
                if (burstFirst < 0) burstFirst = cycleCount;
                lastOutCycle = cycleCount;
            end
            stallValid = m_axis_tvalid && !m_axis_tready;
            stallSnap  = curr;
            if (frame_len_valid) begin
                expLen = (lenQ.size() == 0) ? -1 : lenQ.pop_front();
                checkOutput("frame_len", 64'(frame_len), 64'(expLen));
            end
        end
    end

    int waits;
    int hsBefore;
    logic [S_W/8-1:0] rk;
    int sel;

    initial begin
        axi_aresetn   = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = '0;
        m_axis_tready = 1'b1;
        repeat (2) @(posedge axi_aclk);
        #1;
        checkOutput("reset_m_tvalid", 64'(m_axis_tvalid), 64'(0));
        checkOutput("reset_s_tready", 64'(s_axis_tready), 64'(0));
        checkOutput("reset_frame_len", 64'(frame_len), 64'(0));
        checkOutput("reset_len_valid", 64'(frame_len_valid), 64'(0));
        @(posedge axi_aclk);
        #2 axi_aresetn = 1'b1;
        @(posedge axi_aclk);
        #1;
        checkOutput("idle_s_tready", 64'(s_axis_tready), 64'(1));

        // Full beat, both lanes, closing the frame: 8 bytes.
        applyStimulus(64'h1111_2222_3333_4444, 8'hFF, 1'b1, 1'b1, waits);
        s_axis_tvalid = 1'b0;
        checkOutput("first_latency", 64'(m_axis_tvalid), 64'(1));
        waitDrain();

        // Back-to-back full beats: each beat holds the input for RATIO cycles.
        burstFirst = -1;
        hsBefore   = outHsCount;
        for (int i = 0; i < 4; i++) begin
            applyStimulus({$urandom, $urandom}, 8'hFF, i == 3, 1'($urandom), waits);
            if (i > 0) checkOutput("b2b_wait", 64'(waits), 64'(RATIO - 1));
        end
        s_axis_tvalid = 1'b0;
        waitDrain();
        checkOutput("b2b_count", 64'(outHsCount - hsBefore), 64'(8));
        checkOutput("b2b_span", 64'(lastOutCycle - burstFirst), 64'(7));

        // Sparse keep: only the upper lane survives.
        applyStimulus({$urandom, $urandom}, 8'hF0, 1'b1, 1'b0, waits);
        s_axis_tvalid = 1'b0;
        waitDrain();

        // Partial tail: 4 + 4 + 3 bytes.
        applyStimulus({$urandom, $urandom}, 8'hFF, 1'b0, 1'b1, waits);
        applyStimulus({$urandom, $urandom}, 8'h07, 1'b1, 1'b1, waits);
        s_axis_tvalid = 1'b0;
        waitDrain();

        // Empty beats: dropped mid-frame, keep-0 terminator at the end.
        applyStimulus({$urandom, $urandom}, 8'h00, 1'b0, 1'b0, waits);
        s_axis_tvalid = 1'b0;
        checkOutput("drop_no_output", 64'(m_axis_tvalid), 64'(0));
        applyStimulus({$urandom, $urandom}, 8'h00, 1'b1, 1'b1, waits);
        s_axis_tvalid = 1'b0;
        waitDrain();

        // Random traffic under random backpressure.
        readyMode = 1;
        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 9);
            rk  = (sel == 0) ? 8'h00 : (sel < 5) ? 8'hFF : 8'($urandom);
            applyStimulus({$urandom, $urandom}, rk, ($urandom_range(0, 3) == 0), 1'($urandom), waits);
            if ($urandom_range(0, 3) == 0) begin
                s_axis_tvalid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge axi_aclk);
                #1;
            end
        end
        applyStimulus({$urandom, $urandom}, 8'hFF, 1'b1, 1'b0, waits);
        s_axis_tvalid = 1'b0;
        waitDrain();

        // Reset in the middle of a frame discards everything held.
        readyMode = 0;
        applyStimulus({$urandom, $urandom}, 8'hFF, 1'b0, 1'b1, waits);
        s_axis_tvalid = 1'b0;
        #3 axi_aresetn = 1'b0;
        #1;
        checkOutput("midreset_m_tvalid", 64'(m_axis_tvalid), 64'(0));
        checkOutput("midreset_s_tready", 64'(s_axis_tready), 64'(0));
        expQ.delete();
        lenQ.delete();
        frameSum = 0;
        repeat (3) @(posedge axi_aclk);
        #2 axi_aresetn = 1'b1;
        @(posedge axi_aclk);
        #1;
        readyMode = 1;
        applyStimulus({$urandom, $urandom}, 8'hFF, 1'b0, 1'b0, waits);
        applyStimulus({$urandom, $urandom}, 8'h0F, 1'b1, 1'b0, waits);
        s_axis_tvalid = 1'b0;
        waitDrain();

        checkOutput("end_exp_empty", 64'(expQ.size()), 64'(0));
        checkOutput("end_len_empty", 64'(lenQ.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
